// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low column drive, debounces a single
// pressed key, and shifts each accepted hex code into a 32-bit entry register.
module hex_keypad_scanner #(
  parameter int unsigned SCAN_COUNT     = 100_000,
  parameter int unsigned DEBOUNCE_COUNT = 1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  row_in,
  input  logic        clear_in,
  output logic [3:0]  col_out,
  output logic [3:0]  key_out,
  output logic        key_valid_out,
  output logic        key_down_out,
  output logic [31:0] value_out
);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  localparam logic [31:0] SCAN_LAST = SCAN_COUNT;
  localparam logic [31:0] DEB_LAST  = DEBOUNCE_COUNT - 1;

  state_t      state_q, state_d;
  logic [31:0] scan_cnt_q, scan_cnt_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]  row_meta_q, row_meta_d;
  logic [3:0]  row_s_q, row_s_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  key_q, key_d;
  logic        valid_q, valid_d;
  logic        down_q, down_d;
  logic [31:0] value_q, value_d;
  logic        accept;
  logic [3:0]  code;

  function automatic logic single_low(input logic [3:0] rows);
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] rotate_col(input logic [3:0] col);
    rotate_col = {col[2:0], col[3]};
  endfunction

  function automatic logic [3:0] key_code(input logic [3:0] row_pat, input logic [3:0] col_drv);
    logic [1:0] r;
    logic [1:0] c;
    case (row_pat)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    case (col_drv)
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: c = 2'd0;
    endcase
    // Row 3 holds the '*' and '#' keys, mapped to E and F around 0 and D.
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    col_d      = col_q;
    pat_d      = pat_q;
    key_d      = key_q;
    valid_d    = 1'b0;
    down_d     = down_q;
    value_d    = value_q;
    row_meta_d = row_in;
    row_s_d    = row_meta_q;
    accept     = 1'b0;
    code       = key_code(pat_q, col_q);

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          // Ghosted multi-key patterns are ignored; only a lone low row is chased.
          if (single_low(row_s_q)) begin
            pat_d     = row_s_q;
            deb_cnt_d = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = rotate_col(col_q);
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 32'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (row_s_q != pat_q) begin
          state_d    = ST_SCAN;
          col_d      = rotate_col(col_q);
          scan_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          accept  = 1'b1;
          key_d   = code;
          valid_d = 1'b1;
          down_d  = 1'b1;
          state_d = ST_PRESSED;
        end else begin
          deb_cnt_d = deb_cnt_q + 32'd1;
        end
      end
      ST_PRESSED: begin
        if (row_s_q == 4'hF) begin
          state_d   = ST_RELEASE;
          deb_cnt_d = '0;
        end
      end
      ST_RELEASE: begin
        if (row_s_q != 4'hF) begin
          state_d = ST_PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          down_d     = 1'b0;
          state_d    = ST_SCAN;
          col_d      = rotate_col(col_q);
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    // A clear coinciding with an accept wipes the old digits but keeps the new one.
    if (accept) begin
      value_d = clear_in ? {28'h0, code} : {value_q[27:0], code};
    end else if (clear_in) begin
      value_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_SCAN;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
      pat_q      <= 4'hF;
      col_q      <= 4'b1110;
      key_q      <= '0;
      valid_q    <= 1'b0;
      down_q     <= 1'b0;
      value_q    <= '0;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      row_meta_q <= row_meta_d;
      row_s_q    <= row_s_d;
      pat_q      <= pat_d;
      col_q      <= col_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      down_q     <= down_d;
      value_q    <= value_d;
    end
  end

  assign col_out       = col_q;
  assign key_out       = key_q;
  assign key_valid_out = valid_q;
  assign key_down_out  = down_q;
  assign value_out     = value_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: a keypad model drives the rows from the column drive,
// and a cycle-level behavioural model predicts every output.
module tb_hex_keypad_scanner;

  localparam int SC = 4;
  localparam int DC = 8;
  localparam int M_SCAN  = 0;
  localparam int M_DEB   = 1;
  localparam int M_PRESS = 2;
  localparam int M_REL   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  row_in;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        valid;
  logic        down;
  logic [31:0] value;
  logic [15:0] keys;
  logic        chk_en;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic prev_valid = 1'b0;

  // Key legend indexed by row*4 + column.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model state
  logic [3:0]  m_s1, m_s2, m_pat, m_key;
  int          m_col, m_scan, m_mode, m_cnt;
  logic        m_valid, m_down, m_acc_next;
  logic [31:0] m_value;

  always #5 clk = ~clk;

  hex_keypad_scanner #(.SCAN_COUNT(SC), .DEBOUNCE_COUNT(DC)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .row_in        (row_in),
    .clear_in      (clear),
    .col_out       (col),
    .key_out       (key),
    .key_valid_out (valid),
    .key_down_out  (down),
    .value_out     (value)
  );

  function automatic logic [3:0] rows_for(input logic [3:0] c_drv, input logic [15:0] k);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!c_drv[c] && k[r*4+c]) rows[r] = 1'b0;
    return rows;
  endfunction

  function automatic logic [3:0] col_drive(input int idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  assign row_in = rows_for(col, keys);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] rs;
    logic       acc;
    logic [3:0] code;
    int         r;
    if (rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF; m_key = 4'h0;
      m_col = 0; m_scan = 0; m_mode = M_SCAN; m_cnt = 0;
      m_valid = 1'b0; m_down = 1'b0; m_value = 32'h0;
      return;
    end
    rs      = m_s2;
    m_s2    = m_s1;
    m_s1    = rows_for(col_drive(m_col), keys);
    m_valid = 1'b0;
    acc     = 1'b0;
    case (m_mode)
      M_SCAN: begin
        if (m_scan == SC) begin
          m_scan = 0;
          if ($countones(~rs) == 1) begin
            m_pat = rs; m_mode = M_DEB; m_cnt = 0;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else begin
          m_scan++;
        end
      end
      M_DEB: begin
        if (rs != m_pat) begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_scan = 0;
        end else begin
          m_cnt++;
          if (m_cnt == DC) begin acc = 1'b1; m_mode = M_PRESS; end
        end
      end
      M_PRESS: if (rs == 4'hF) begin m_mode = M_REL; m_cnt = 0; end
      default: begin
        if (rs != 4'hF) m_mode = M_PRESS;
        else begin
          m_cnt++;
          if (m_cnt == DC) begin
            m_down = 1'b0; m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_scan = 0;
          end
        end
      end
    endcase
    if (acc) begin
      r = 0;
      for (int i = 0; i < 4; i++) if (!m_pat[i]) r = i;
      code    = keymap[r*4 + m_col];
      m_key   = code;
      m_valid = 1'b1;
      m_down  = 1'b1;
      m_value = clear ? {28'h0, code} : {m_value[27:0], code};
    end else if (clear) begin
      m_value = 32'h0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("col_out", {28'h0, col}, {28'h0, col_drive(m_col)});
      chk("key_out", {28'h0, key}, {28'h0, m_key});
      chk("key_valid_out", {31'h0, valid}, {31'h0, m_valid});
      chk("key_down_out", {31'h0, down}, {31'h0, m_down});
      chk("value_out", value, m_value);
      chk("valid_back_to_back", {31'h0, valid & prev_valid}, 32'h0);
      if (valid === 1'b1) pulses++;
      prev_valid = valid;
    end
    model_step();
    m_acc_next = (m_mode == M_DEB) && (m_cnt == DC - 1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int budget;
    int seq [9];
    int n;
    seq = '{0, 1, 2, 3, 12, 13, 14, 15, 10};
    rst = 1'b1; clear = 1'b0; keys = 16'h0; chk_en = 1'b0; m_acc_next = 1'b0;
    tick(3);
    rst = 1'b0; chk_en = 1'b1;
    chk("reset col_out", {28'h0, col}, 32'hE);
    chk("reset key_out", {28'h0, key}, 32'h0);
    chk("reset key_valid", {31'h0, valid}, 32'h0);
    chk("reset key_down", {31'h0, down}, 32'h0);
    chk("reset value_out", value, 32'h0);

    // Idle scanning
    tick(100);
    chk("idle pulses", pulses, 0);
    chk("idle value", value, 32'h0);

    // Hold '5'
    keys = 16'h0020;
    tick(200);
    chk("hold5 pulses", pulses, 1);
    chk("hold5 key", {28'h0, key}, 32'h5);
    chk("hold5 value", value, 32'h5);
    chk("hold5 down", {31'h0, down}, 32'h1);
    keys = 16'h0;
    tick(60);
    chk("release5 down", {31'h0, down}, 32'h0);

    // Key sequence 1 2 3 A E 0 F D 9, with random extra hold/gap lengths
    foreach (seq[i]) begin
      keys = 16'h0;
      keys[seq[i]] = 1'b1;
      tick(60 + int'($urandom_range(0, 40)));
      keys = 16'h0;
      tick(50 + int'($urandom_range(0, 30)));
    end
    chk("sequence value", value, 32'h23AE0FD9);
    chk("sequence pulses", pulses, 10);

    // Bouncing '7' never settles
    repeat (20) begin
      keys = 16'h0100; tick(5);
      keys = 16'h0;    tick(3);
    end
    tick(40);
    chk("bounce7 pulses", pulses, 10);

    // Hold '8', bounce on release
    keys = 16'h0200;
    tick(100);
    repeat (10) begin
      keys = 16'h0;    tick(3);
      keys = 16'h0200; tick(5);
    end
    keys = 16'h0;
    tick(60);
    chk("bounce8 pulses", pulses, 11);
    chk("bounce8 key", {28'h0, key}, 32'h8);
    chk("bounce8 value", value, 32'h3AE0FD98);

    // Two keys in column 0 ghost out; lifting one leaves '1'
    keys = 16'h0011;
    tick(100);
    chk("ghost pulses", pulses, 11);
    keys = 16'h0001;
    tick(80);
    chk("ghost release pulses", pulses, 12);
    chk("ghost release key", {28'h0, key}, 32'h1);
    keys = 16'h0;
    tick(60);
    chk("ghost value", value, 32'hAE0FD981);

    // Clear in the accept cycle of '7'
    keys = 16'h0100;
    budget = 0;
    while (!m_acc_next && budget < 300) begin
      tick(1);
      budget++;
    end
    chk("accept7 reached", {31'h0, m_acc_next}, 32'h1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear+accept valid", {31'h0, valid}, 32'h1);
    chk("clear+accept key", {28'h0, key}, 32'h7);
    chk("clear+accept value", value, 32'h7);
    keys = 16'h0;
    tick(60);
    chk("clear+accept pulses", pulses, 13);

    // Reset in the middle of debouncing 'B'
    keys = 16'h0080;
    budget = 0;
    while (m_mode != M_DEB && budget < 300) begin
      tick(1);
      budget++;
    end
    chk("debounceB reached", (m_mode == M_DEB) ? 32'h1 : 32'h0, 32'h1);
    tick(3);
    rst = 1'b1;
    keys = 16'h0;
    tick(1);
    rst = 1'b0;
    chk("midreset col_out", {28'h0, col}, 32'hE);
    chk("midreset key_out", {28'h0, key}, 32'h0);
    chk("midreset value", value, 32'h0);
    chk("midreset down", {31'h0, down}, 32'h0);
    n = pulses;
    tick(60);
    chk("midreset pulses", pulses, n);
    chk("midreset total pulses", pulses, 13);
    chk("midreset value later", value, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
